main_memory: RTL and testbench
==============================

MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1<<13, backing-store size in 32-bit words (power of two, ≥4).
REQ-002 SHALL have parameter REQ_DELAY, default 5, request-path latency in cycles (≥1).
REQ-003 SHALL have parameter RESP_DELAY, default 5, response-path latency in cycles (≥1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  cache presents a line request.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = line writeback, 0 = line fill.
REQ-009 SHALL have port req_addr  input  32  byte address; bits [3:0] ignored (line aligned).
REQ-010 SHALL have port req_wdata  input  128  writeback line; word 0 in [31:0].
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  cache consumes response.
REQ-013 SHALL have port resp_rdata  output  128  fill line; word 0 in [31:0]; zero for writes.
REQ-014 SHALL have port resp_err  output  1  request addressed beyond MEM_DEPTH.

Function
REQ-015 SHALL implement FSM IDLE -> REQ -> RESP -> DONE -> IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready at an edge; captures write flag, addr, wdata.
REQ-017 REQ SHALL last exactly REQ_DELAY cycles; on its last edge the array access occurs (write 4 words or read 4 words into response register).
REQ-018 RESP SHALL last exactly RESP_DELAY cycles; then DONE.
REQ-019 resp_valid SHALL be 1 only in DONE, first asserting exactly REQ_DELAY+RESP_DELAY cycles after the acceptance edge.
REQ-020 resp_valid, resp_rdata, resp_err SHALL remain stable in DONE until resp_valid && resp_ready; that edge returns to IDLE.
REQ-021 Line word index SHALL be {req_addr[31:4],2'b00}; words i=0..3 map to index+i.
REQ-022 Inputs other than those captured at acceptance SHALL be ignored while not in IDLE.
REQ-023 A fill issued after a writeback to the same line SHALL return the written data.
REQ-024 Only one request SHALL be outstanding; no pipelining or reordering.

Reset
REQ-025 Reset SHALL force IDLE, clear counters, req_ready=1 after reset releases, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-026 Reset asserted mid-operation SHALL abort the request; a writeback not yet at its access edge SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro BRISC_MEM_RANGE_CHECK_EN defined: line with word index+3 ≥ MEM_DEPTH SHALL set resp_err=1, resp_rdata=0, and perform no write; latency unchanged.
REQ-029 Macro undefined: word index SHALL be truncated to $clog2(MEM_DEPTH) bits (address wraps) and resp_err SHALL be tied 0.

Verification
REQ-030 Reset, then write addr 0x4000 data 0x...DDDD_CCCC_BBBB_AAAA -> resp_valid exactly 10 cycles after acceptance, resp_err=0, resp_rdata=0.
REQ-031 Fill addr 0x400C after REQ-030 -> resp_rdata word0=0xAAAA, word3=0xDDDD (low bits ignored), latency 10.
REQ-032 resp_ready held 0 for 7 cycles in DONE -> resp_valid and data stable all 7 cycles; req_ready=0 until handshake edge.
REQ-033 req_valid held high back-to-back -> second request accepted only the cycle after first resp handshake.
REQ-034 Reset asserted 3 cycles after accepting write to 0x5000 -> later fill of 0x5000 returns prior contents; resp_valid=0 immediately.
REQ-035 Fill addr 0x8000 (word index 8192 = MEM_DEPTH): with BRISC_MEM_RANGE_CHECK_EN resp_err=1, rdata=0; without, returns line at word index 0.

Source files
------------

// File: rtl/main_memory.sv
// main_memory: line-oriented backing store with fixed request/response latency.
// Define BRISC_MEM_RANGE_CHECK_EN to flag out-of-range lines instead of wrapping.
module main_memory #(
    parameter int MEM_DEPTH  = 1 << 13,
    parameter int REQ_DELAY  = 5,
    parameter int RESP_DELAY = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         resp_err
);

    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int MAXD = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [CW-1:0] REQ_LAST  = CW'(REQ_DELAY - 1);
    localparam logic [CW-1:0] RESP_LAST = CW'(RESP_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            accept;
    logic            access;

    logic            write_q;
    logic [27:0]     line_q;
    logic [127:0]    wdata_q;
    logic [127:0]    rdata_q;

    logic [29:0]     widx_full;
    logic [AW-1:0]   base;
    logic            oor;
    logic [127:0]    rd_line;
    logic            unused_bits;

    logic [31:0]     mem [MEM_DEPTH];

    assign accept     = req_valid && (state_q == IDLE);
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_rdata = rdata_q;

    assign widx_full  = {line_q, 2'b00};
    assign base       = widx_full[AW-1:0];

`ifdef BRISC_MEM_RANGE_CHECK_EN
    logic err_q;

    // A line is out of range when its last word index reaches MEM_DEPTH.
    assign oor         = ({4'b0, line_q} >= 32'(MEM_DEPTH / 4));
    assign resp_err    = err_q;
    assign unused_bits = ^req_addr[3:0];

    // Error flag is produced at the access edge and held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= oor;
        end
    end
`else
    assign oor         = 1'b0;
    assign resp_err    = 1'b0;
    assign unused_bits = ^{widx_full[29:AW], req_addr[3:0]};
`endif

    // Gather the four words of the addressed line, word 0 in the low bits.
    always_comb begin
        rd_line = '0;
        for (int i = 0; i < 4; i++) begin
            rd_line[32*i +: 32] = mem[base | AW'(i)];
        end
    end

    // State and latency counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the access strobe fires on the last REQ cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cnt_q == REQ_LAST) begin
                    access  = 1'b1;
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (cnt_q == RESP_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request capture at acceptance and response data at the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                line_q  <= req_addr[31:4];
                wdata_q <= req_wdata;
            end
            if (access) begin
                rdata_q <= (write_q || oor) ? '0 : rd_line;
            end
        end
    end

    // Array write; contents survive reset, and an aborted writeback never lands.
    always_ff @(posedge clk) begin
        if (!reset && access && write_q && !oor) begin
            for (int i = 0; i < 4; i++) begin
                mem[base | AW'(i)] <= wdata_q[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed checks of latency, handshake, reset abort and wrap.
// Expected values are hand-computed constants in this file.
module tb_main_memory;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_rdata;
    logic         resp_err;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [127:0] LINE_A = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    localparam logic [127:0] LINE_S = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_P = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    localparam logic [127:0] LINE_Q = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    localparam logic [127:0] LINE_R = 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001;

    main_memory dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after its acceptance edge.
    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [127:0] wd, input logic hold);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Count edges from acceptance until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid) break;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic xact(input logic wr, input logic [31:0] a,
                        input logic [127:0] wd, output int lat,
                        output logic [127:0] rd, output logic err);
        issue(wr, a, wd, 1'b0);
        wait_resp(lat);
        rd  = resp_rdata;
        err = resp_err;
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [127:0] rd;
        logic         err;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_rdata", resp_rdata, 128'd0);
        check("rst_err", 128'(resp_err), 128'd0);

        xact(1'b1, 32'h0000_4000, LINE_A, lat, rd, err);
        check("wr_lat", 128'(lat), 128'd10);
        check("wr_err", 128'(err), 128'd0);
        check("wr_rdata", rd, 128'd0);

        xact(1'b0, 32'h0000_400C, '0, lat, rd, err);
        check("rd_lat", 128'(lat), 128'd10);
        check("rd_word0", 128'(rd[31:0]), 128'h0000AAAA);
        check("rd_word3", 128'(rd[127:96]), 128'h0000DDDD);
        check("rd_line", rd, LINE_A);
        check("rd_err", 128'(err), 128'd0);

        xact(1'b1, 32'h0000_0100, LINE_S, lat, rd, err);
        issue(1'b0, 32'h0000_0104, '0, 1'b0);
        wait_resp(lat);
        check("stall_lat", 128'(lat), 128'd10);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 128'(resp_valid), 128'd1);
            check("stall_rdata", resp_rdata, LINE_S);
            check("stall_ready", 128'(req_ready), 128'd0);
        end
        handshake();
        check("stall_hs_valid", 128'(resp_valid), 128'd0);
        check("stall_hs_ready", 128'(req_ready), 128'd1);

        @(negedge clk);
        resp_ready = 1'b1;
        issue(1'b0, 32'h0000_4000, '0, 1'b1);
        wait_resp(lat);
        check("b2b_lat1", 128'(lat), 128'd10);
        @(posedge clk);
        #1;
        check("b2b_hs_ready", 128'(req_ready), 128'd1);
        check("b2b_hs_valid", 128'(resp_valid), 128'd0);
        @(posedge clk);
        #1;
        check("b2b_accept", 128'(req_ready), 128'd0);
        req_valid = 1'b0;
        wait_resp(lat);
        check("b2b_lat2", 128'(lat), 128'd10);
        check("b2b_rdata", resp_rdata, LINE_A);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("b2b_done", 128'(resp_valid), 128'd0);

        xact(1'b1, 32'h0000_5000, LINE_P, lat, rd, err);
        issue(1'b1, 32'h0000_5000, LINE_Q, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", 128'(resp_valid), 128'd0);
        check("abort_ready", 128'(req_ready), 128'd1);
        check("abort_rdata", resp_rdata, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        xact(1'b0, 32'h0000_5000, '0, lat, rd, err);
        check("abort_fill", rd, LINE_P);
        check("abort_lat", 128'(lat), 128'd10);

        xact(1'b1, 32'h0000_0000, LINE_R, lat, rd, err);
        xact(1'b0, 32'h0000_8000, '0, lat, rd, err);
        check("oob_lat", 128'(lat), 128'd10);
`ifdef BRISC_MEM_RANGE_CHECK_EN
        check("oob_err", 128'(err), 128'd1);
        check("oob_rdata", rd, 128'd0);
`else
        check("oob_err", 128'(err), 128'd0);
        check("oob_rdata", rd, LINE_R);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
